// File: rtl/dff_share_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding, counter
// width and a helper for sizing requester index fields.
package dff_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int WR_CNT_W = 8;

  // Index width for n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_share_arb_rr_pick.sv
// Round-robin picker: returns the first asserted request at or after ptr,
// wrapping modulo N_REQ, as both a one-hot vector and a binary index.
module rr_pick
  import dff_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  assign any = |req;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    logic [IDX_W:0]   raw_v;
    logic [IDX_W:0]   sum_v;
    logic [IDX_W-1:0] pos_v;
    logic             found_v;
    onehot  = '0;
    idx     = '0;
    found_v = 1'b0;
    raw_v   = '0;
    sum_v   = '0;
    pos_v   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      raw_v = {1'b0, ptr} + (IDX_W+1)'(off);
      // ptr and off are both below N_REQ, so one subtraction wraps fully.
      sum_v = (raw_v >= (IDX_W+1)'(N_REQ)) ? (raw_v - (IDX_W+1)'(N_REQ)) : raw_v;
      pos_v = sum_v[IDX_W-1:0];
      if (!found_v && req[pos_v]) begin
        found_v       = 1'b1;
        onehot[pos_v] = 1'b1;
        idx           = pos_v;
      end else begin
        found_v = found_v;
      end
    end
  end

endmodule

// File: rtl/dff_share_arb.sv
// Shared data register written by N_REQ requesters through a round-robin
// IDLE -> GRANT -> ACK handshake. All outputs come straight from registers.
module dff_share_arb
  import dff_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] d_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   busy,
  output logic [WR_CNT_W-1:0]    wr_count
);

  localparam int IDX_W = idx_width(N_REQ);

  state_e              state_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    ack_q;
  logic [WIDTH-1:0]    q_q;
  logic                q_valid_q;
  logic                busy_q;
  logic [WR_CNT_W-1:0] wr_count_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    idx_q;

  logic [N_REQ-1:0]    pick_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic                req_held_s;
  logic [IDX_W-1:0]    ptr_next_s;
  logic [WIDTH-1:0]    d_slice_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign d_slice_s[g] = d_in[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // The granted requester is still asserting its request.
  assign req_held_s = |(req & gnt_q);
  assign ptr_next_s = (idx_q == IDX_W'(N_REQ-1)) ? '0 : (idx_q + IDX_W'(1));

  // Arbitration FSM with registered grant/ack, data register and write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (pick_any_s) begin
            gnt_q   <= pick_onehot_s;
            idx_q   <= pick_idx_s;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end else begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          gnt_q <= '0;
          if (req_held_s) begin
            // Data is taken as it stands on this edge, not at grant time.
            q_q        <= d_slice_s[idx_q];
            q_valid_q  <= 1'b1;
            ack_q      <= gnt_q;
            wr_count_q <= wr_count_q + WR_CNT_W'(1'b1);
            busy_q     <= 1'b1;
            state_q    <= ST_ACK;
          end else begin
            // Requester withdrew: drop the grant, keep priority where it was.
            ack_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACK: begin
          ack_q    <= '0;
          gnt_q    <= '0;
          rr_ptr_q <= ptr_next_s;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: doc/dff_share_arb.md
DFF_SHARE_ARB -- requirements
Module: dff_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the register (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  N_REQ  per-requester write request, level.
REQ-006 SHALL have port d_in  input  N_REQ*WIDTH  packed write data; requester i occupies d_in[i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-008 SHALL have port ack  output  N_REQ  one-hot, one-cycle write-done pulse, registered.
REQ-009 SHALL have port q  output  WIDTH  shared register contents.
REQ-010 SHALL have port q_valid  output  1  high once q holds at least one written value.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port wr_count  output  8  count of completed writes.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, ACK; encoding from shared package.
REQ-014 IDLE: if any req bit high, SHALL pick the first set bit at or after rr_ptr (wrapping modulo N_REQ), register its one-hot in gnt, go to GRANT; else stay IDLE with gnt=0.
REQ-015 GRANT: if req[idx] still high, SHALL load q <= d_in slice idx, set q_valid, go to ACK; if req[idx] low, SHALL abort (no write, gnt cleared, rr_ptr unchanged), go to IDLE.
REQ-016 ACK: ack[idx] SHALL be high for exactly this cycle, gnt cleared; rr_ptr <= (idx+1) mod N_REQ; wr_count += 1, wrapping 255 -> 0; go to IDLE.
REQ-017 Latency: req sampled high in IDLE at edge k -> gnt high after edge k, q updated and ack high after edge k+1, FSM back in IDLE after edge k+2; max one write per 3 cycles.
REQ-018 gnt and ack SHALL never both be nonzero; each SHALL have at most one bit set.
REQ-019 Requests arriving in GRANT/ACK SHALL be held off (no gnt) until the next IDLE evaluation; no request is lost while held high.
REQ-020 With all N_REQ requesting continuously, grants SHALL rotate strictly 0,1,...,N_REQ-1,0 (starvation-free).
REQ-021 Change of d_in of the granted requester during GRANT SHALL be captured as sampled on the GRANT-cycle edge.
REQ-022 q SHALL hold its value in every state except the GRANT->ACK transition.

Reset
REQ-023 On rst high at a rising edge: state=IDLE, gnt=0, ack=0, q=0, q_valid=0, busy=0, wr_count=0, rr_ptr=0.
REQ-024 rst mid-transaction (GRANT or ACK) SHALL discard the transaction: no ack pulse, no wr_count increment, reset values override.
REQ-025 rst SHALL take priority over every other state update in the same cycle.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (2-bit IDLE=0, GRANT=1, ACK=2) and the wr_count width constant.
REQ-027 Round-robin priority selection (req, rr_ptr -> one-hot, any) SHALL be one combinational sub-module rr_pick; FSM, register and counter stay in dff_share_arb.
REQ-028 The state value 3 SHALL recover to IDLE.

Verification
REQ-029 Single request: N_REQ=4, req=4'b0100, d_in slice 2=8'hA5 -> gnt=4'b0100 one cycle later, next cycle q=8'hA5, ack=4'b0100, q_valid=1, wr_count=1.
REQ-030 Full contention: req=4'b1111 held 12 cycles from reset -> ack order 0,1,2,3 repeating, one ack every 3 cycles, wr_count=4 after 12 cycles.
REQ-031 Abort: req[1] high in IDLE, low in GRANT cycle -> no ack, q unchanged, wr_count unchanged, next grant still chooses requester 1 first if it re-requests with requester 2.
REQ-032 Reset mid-op: assert rst during ACK of a write of 8'h3C -> q=0, q_valid=0, wr_count=0, ack=0 next cycle.
REQ-033 Counter wrap: 256 completed writes from reset -> wr_count=0, q holds last written value.
REQ-034 Pointer wrap: after ack to requester 3, req=4'b1001 -> grant to requester 0, then to 3.
